// File: rtl/scan_cfg_loader.sv
// ---------------------------------------------------------------------------
// scan_cfg_loader
//
// Purpose:
//   Transmit end of the fabric configuration scan chains. Configuration
//   bytes arrive on a valid/ready stream. Each byte is serialized MSB-first,
//   first onto the CLB chain and then onto the connection chain. The block
//   also generates the registered scan clock and the per-chain shift
//   enables. Each bit takes two clk cycles: an L phase with scan_clk low and
//   data presented, then an H phase with scan_clk high.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          one-cycle load request (ignored while busy)
//   o_busy           load in progress
//   o_done           one-cycle pulse when both chains are loaded
//   i_cfg_data       configuration byte, bit 7 shifted first
//   i_cfg_valid      i_cfg_data is valid
//   o_cfg_ready      loader can take a byte this cycle
//   o_scan_clk       registered scan clock to the fabric
//   o_clb_scan_in    serial data into the CLB chain
//   o_clb_scan_en    CLB chain shift enable
//   o_conn_scan_in   serial data into the connection chain
//   o_conn_scan_en   connection chain shift enable
//   i_clb_scan_out   CLB chain tail (readback only)
//   i_conn_scan_out  connection chain tail (readback only)
//   o_readback_crc   CRC-16-CCITT of shifted-out bits
//
// Build option:
//   SCAN_READBACK_EN  when defined, each scan_clk rise folds the active
//                     chain's tail bit into o_readback_crc (poly 0x1021,
//                     MSB-first, seeded 0xFFFF on an accepted start).
//                     Otherwise o_readback_crc is tied to 0.
// ---------------------------------------------------------------------------
module scan_cfg_loader #(
    parameter int CLB_CHAIN_LEN  = 64,
    parameter int CONN_CHAIN_LEN = 256,
    parameter int CNT_W          = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    input  logic [7:0]  i_cfg_data,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    output logic        o_scan_clk,
    output logic        o_clb_scan_in,
    output logic        o_clb_scan_en,
    output logic        o_conn_scan_in,
    output logic        o_conn_scan_en,
    input  logic        i_clb_scan_out,
    input  logic        i_conn_scan_out,
    output logic [15:0] o_readback_crc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLB_SHIFT,
        S_CONN_SHIFT,
        S_FINISH
    } state_t;

    localparam logic [CNT_W-1:0] CLB_LEN_C  = CNT_W'(CLB_CHAIN_LEN);
    localparam logic [CNT_W-1:0] CONN_LEN_C = CNT_W'(CONN_CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    state_t           r_state;
    logic [7:0]       r_buf;
    logic [3:0]       r_buf_cnt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_scan_clk;
    logic             r_clb_si;
    logic             r_clb_en;
    logic             r_conn_si;
    logic             r_conn_en;

    logic w_in_shift;
    logic w_is_clb;
    logic w_take;
    logic w_chain_end;

    assign w_in_shift  = (r_state == S_CLB_SHIFT) || (r_state == S_CONN_SHIFT);
    assign w_is_clb    = (r_state == S_CLB_SHIFT);
    // A byte is only taken between bits, so the H phase never sees the
    // buffer change under it.
    assign o_cfg_ready = w_in_shift && (r_buf_cnt == 4'd0) && !r_scan_clk;
    assign w_take      = o_cfg_ready && i_cfg_valid;
    assign w_chain_end = (r_bit_cnt == CNT_ONE_C);

`ifdef SCAN_READBACK_EN
    logic [15:0] r_crc;
    logic        w_tail_bit;
    logic        w_crc_fb;
    logic [15:0] w_crc_next;

    assign w_tail_bit     = w_is_clb ? i_clb_scan_out : i_conn_scan_out;
    assign w_crc_fb       = r_crc[15] ^ w_tail_bit;
    assign w_crc_next     = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    assign o_readback_crc = r_crc;
`else
    // Tail inputs only matter for readback; keep them referenced.
    logic w_unused_tail;
    assign w_unused_tail  = i_clb_scan_out ^ i_conn_scan_out;
    assign o_readback_crc = 16'h0000;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_buf      <= 8'h00;
            r_buf_cnt  <= 4'd0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_scan_clk <= 1'b0;
            r_clb_si   <= 1'b0;
            r_clb_en   <= 1'b0;
            r_conn_si  <= 1'b0;
            r_conn_en  <= 1'b0;
`ifdef SCAN_READBACK_EN
            r_crc      <= 16'h0000;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_CLB_SHIFT;
                        r_busy    <= 1'b1;
                        r_clb_en  <= 1'b1;
                        r_bit_cnt <= CLB_LEN_C;
`ifdef SCAN_READBACK_EN
                        r_crc     <= 16'hFFFF;
`endif
                    end
                end

                S_CLB_SHIFT, S_CONN_SHIFT: begin
                    if (r_scan_clk) begin
                        // Falling scan_clk: bit is consumed by the fabric.
                        r_scan_clk <= 1'b0;
                        if (w_chain_end) begin
                            // Leftover bits of the byte are dropped so the
                            // next chain starts on a fresh byte.
                            r_buf     <= 8'h00;
                            r_buf_cnt <= 4'd0;
                            r_clb_si  <= 1'b0;
                            r_conn_si <= 1'b0;
                            if (w_is_clb) begin
                                r_state   <= S_CONN_SHIFT;
                                r_bit_cnt <= CONN_LEN_C;
                                r_clb_en  <= 1'b0;
                                r_conn_en <= 1'b1;
                            end else begin
                                r_state   <= S_FINISH;
                                r_bit_cnt <= '0;
                                r_conn_en <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end else begin
                            r_buf     <= {r_buf[6:0], 1'b0};
                            r_buf_cnt <= r_buf_cnt - 4'd1;
                            r_bit_cnt <= r_bit_cnt - CNT_ONE_C;
                            // buf[6] becomes the new MSB; it is already 0
                            // once the last bit of the byte has gone out.
                            r_clb_si  <= w_is_clb & r_buf[6];
                            r_conn_si <= !w_is_clb & r_buf[6];
                        end
                    end else if (r_buf_cnt != 4'd0) begin
                        // L phase done, raise scan_clk for the fabric capture.
                        r_scan_clk <= 1'b1;
`ifdef SCAN_READBACK_EN
                        r_crc      <= w_crc_next;
`endif
                    end else if (w_take) begin
                        r_buf     <= i_cfg_data;
                        r_buf_cnt <= 4'd8;
                        r_clb_si  <= w_is_clb & i_cfg_data[7];
                        r_conn_si <= !w_is_clb & i_cfg_data[7];
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_scan_clk     = r_scan_clk;
    assign o_clb_scan_in  = r_clb_si;
    assign o_clb_scan_en  = r_clb_en;
    assign o_conn_scan_in = r_conn_si;
    assign o_conn_scan_en = r_conn_en;

endmodule

// File: tb/tb_scan_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_scan_cfg_loader
//
// Purpose:
//   Directed self-checking bench for scan_cfg_loader with a 12-bit CLB chain
//   and an 8-bit connection chain. Each accepted byte pushes the bits its
//   chain should receive into a scoreboard queue. Each scan_clk rise pops one
//   expected {chain, bit} entry and compares it with the enables and scan
//   inputs seen during the H phase.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_scan_cfg_loader;

    localparam int CLB_LEN  = 12;
    localparam int CONN_LEN = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_cfg_data = 8'h00;
    logic        i_cfg_valid = 1'b0;
    logic        i_clb_scan_out = 1'b1;
    logic        i_conn_scan_out = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic        o_cfg_ready;
    logic        o_scan_clk;
    logic        o_clb_scan_in;
    logic        o_clb_scan_en;
    logic        o_conn_scan_in;
    logic        o_conn_scan_en;
    logic [15:0] o_readback_crc;

    int errors = 0;
    int checks = 0;

    logic [7:0] feed[$];
    logic [1:0] expQ[$];
    int   clbLeft;
    int   connLeft;
    int   bytesTaken;
    int   doneCount;
    int   riseCount;
    int   firstRiseCycle;
    int   cycleIdx;
    logic prevScanClk;

    scan_cfg_loader #(
        .CLB_CHAIN_LEN (CLB_LEN),
        .CONN_CHAIN_LEN(CONN_LEN),
        .CNT_W         (16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .i_cfg_data     (i_cfg_data),
        .i_cfg_valid    (i_cfg_valid),
        .o_cfg_ready    (o_cfg_ready),
        .o_scan_clk     (o_scan_clk),
        .o_clb_scan_in  (o_clb_scan_in),
        .o_clb_scan_en  (o_clb_scan_en),
        .o_conn_scan_in (o_conn_scan_in),
        .o_conn_scan_en (o_conn_scan_en),
        .i_clb_scan_out (i_clb_scan_out),
        .i_conn_scan_out(i_conn_scan_out),
        .o_readback_crc (o_readback_crc)
    );

    always #5 i_clk = ~i_clk;

    // Reference CRC-16-CCITT (0x1021, MSB-first) over n one-bits from 0xFFFF.
    function automatic logic [15:0] crcOnes(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ 1'b1;
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [31:0] allOutputs();
        return {8'd0, o_busy, o_done, o_cfg_ready, o_scan_clk, o_clb_scan_in,
                o_clb_scan_en, o_conn_scan_in, o_conn_scan_en, o_readback_crc};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Expected bits for an accepted byte go to whichever chain still needs
    // bits; bits beyond the chain length are dropped.
    task automatic scheduleByte(input logic [7:0] b);
        int   n;
        logic chain;
        if (clbLeft > 0) begin
            n = (clbLeft < 8) ? clbLeft : 8;
            chain = 1'b0;
            clbLeft -= n;
        end else begin
            n = (connLeft < 8) ? connLeft : 8;
            chain = 1'b1;
            connLeft -= n;
        end
        for (int i = 0; i < n; i++) expQ.push_back({chain, b[7-i]});
    endtask

    // One clk cycle: drive inputs, clock, then monitor the outputs 1ns later.
    task automatic applyStimulus(input logic valid, input logic startPulse);
        logic       accepted;
        logic [7:0] b;
        logic [1:0] e;
        logic [3:0] expBits;
        i_start     = startPulse;
        i_cfg_valid = valid && (feed.size() > 0);
        i_cfg_data  = (feed.size() > 0) ? feed[0] : 8'h00;
        accepted    = i_cfg_valid && o_cfg_ready;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        cycleIdx++;
        if (accepted) begin
            b = feed.pop_front();
            bytesTaken++;
            scheduleByte(b);
        end
        checkOutput("en_exclusive_inactive_zero",
                    {29'd0, o_clb_scan_en & o_conn_scan_en,
                     !o_clb_scan_en & o_clb_scan_in,
                     !o_conn_scan_en & o_conn_scan_in}, 32'd0);
        if (o_scan_clk && !prevScanClk) begin
            riseCount++;
            if (riseCount == 1) firstRiseCycle = cycleIdx;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                expBits = e[1] ? {2'b01, 1'b0, e[0]} : {2'b10, e[0], 1'b0};
            end else begin
                expBits = 4'b1111;
            end
            checkOutput("scan_bit",
                        {28'd0, o_clb_scan_en, o_conn_scan_en, o_clb_scan_in, o_conn_scan_in},
                        {28'd0, expBits});
        end
        prevScanClk = o_scan_clk;
        if (o_done) doneCount++;
    endtask

    // Full load of 0xA5, 0x3F, 0xC3. Optionally stalls cfg_valid for
    // stallLen cycles once the first byte is used up, pulses start again
    // at cycle restartAt, or returns early a few cycles into CONN_SHIFT.
    task automatic runLoad(input int stallLen, input int restartAt, input bit abortInConn);
        int          connCycles;
        int          stallLeft;
        bit          stallUsed;
        bit          stalled;
        bit          finished;
        logic [15:0] expCrc;
        connCycles = 0;
        stallLeft  = 0;
        stallUsed  = 1'b0;
        finished   = 1'b0;
        feed       = '{8'hA5, 8'h3F, 8'hC3};
        expQ.delete();
        clbLeft        = CLB_LEN;
        connLeft       = CONN_LEN;
        bytesTaken     = 0;
        doneCount      = 0;
        riseCount      = 0;
        firstRiseCycle = 0;
        cycleIdx       = 0;
        prevScanClk    = o_scan_clk;
`ifdef SCAN_READBACK_EN
        expCrc = crcOnes(CLB_LEN + CONN_LEN);
`else
        expCrc = 16'h0000;
`endif

        applyStimulus(1'b1, 1'b1);
        checkOutput("busy_after_start", 32'(o_busy), 32'd1);

        for (int k = 0; k < 300 && !finished; k++) begin
            if (stallLen > 0 && !stallUsed && bytesTaken == 1 && o_cfg_ready) begin
                stallUsed = 1'b1;
                stallLeft = stallLen;
            end
            stalled = (stallLeft > 0);
            applyStimulus(!stalled, (cycleIdx == restartAt));
            if (stalled) begin
                stallLeft--;
                checkOutput("stall_frozen", {29'd0, o_scan_clk, o_clb_scan_en, o_cfg_ready},
                            32'b011);
            end
            if (o_done) finished = 1'b1;
            if (abortInConn) begin
                if (o_conn_scan_en) connCycles++;
                if (connCycles == 3) return;
            end
        end

        checkOutput("load_finished", 32'(finished), 32'd1);
        checkOutput("first_rise_latency", 32'(firstRiseCycle), 32'd3);
        checkOutput("scan_rises", 32'(riseCount), 32'(CLB_LEN + CONN_LEN));
        checkOutput("bytes_taken", 32'(bytesTaken), 32'd3);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("done_cycle", {29'd0, o_done, o_busy, o_conn_scan_en}, 32'b110);
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_after_done",
                    {26'd0, o_busy, o_done, o_cfg_ready, o_scan_clk, o_clb_scan_en, o_conn_scan_en},
                    32'd0);
        checkOutput("done_count", 32'(doneCount), 32'd1);
        checkOutput("readback_crc", {16'd0, o_readback_crc}, {16'd0, expCrc});
    endtask

    initial begin
        $display("[TB] scan_cfg_loader bench start");

        // Reset state.
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        i_rst_n = 1'b1;

        // A byte offered while idle must not be taken.
        feed        = '{8'h5A};
        bytesTaken  = 0;
        prevScanClk = 1'b0;
        clbLeft     = 0;
        connLeft    = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("no_accept_idle", 32'(bytesTaken), 32'd0);
        checkOutput("idle_quiet", {29'd0, o_busy, o_cfg_ready, o_scan_clk}, 32'd0);
        feed.delete();

        // Unstalled load.
        runLoad(0, 0, 1'b0);

        // Stalled mid-stream, with a second start pulse while busy.
        runLoad(5, 10, 1'b0);

        // Reset during CONN_SHIFT clears every output at once.
        runLoad(0, 0, 1'b1);
        #1 i_rst_n = 1'b0;
        #1 checkOutput("reset_mid_conn", allOutputs(), 32'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Fresh load after the abort restarts from CLB bit 0.
        runLoad(0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
